// File: rtl/mem_reader_pkg.sv
// ============================================================================
// | Module   : mem_reader_pkg                                                 |
// | Purpose  : Shared types, widths and helpers for the memory dump reader.   |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

package mem_reader_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [ADDR_W-1:0] RAM_BASE = 32'd8500;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Zero or an over-long request both mean "dump the whole window".
    function automatic logic [CNT_W:0] clamp_count(input logic [CNT_W-1:0] cnt,
                                                   input int unsigned     depth);
        if (cnt == '0 || {{(32-CNT_W){1'b0}}, cnt} > depth)
            return (CNT_W+1)'(depth);
        return {1'b0, cnt};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_dump_reader_if.sv
// ============================================================================
// | Module   : mem_dump_reader_if                                             |
// | Purpose  : Data-memory read port plus valid/ready output stream.          |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

interface mem_dump_reader_if;
    import mem_reader_pkg::*;

    logic [ADDR_W-1:0] memAddr;
    logic              memRe;
    logic [DATA_W-1:0] memRd;
    logic              memWriteM;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;

    modport master (
        output memAddr, memRe, outData, outValid,
        input  memRd, memWriteM, outReady
    );

    modport slave (
        input  memAddr, memRe, outData, outValid,
        output memRd, memWriteM, outReady
    );

endinterface

`default_nettype wire

// File: rtl/mem_read_delay.sv
// ============================================================================
// | Module   : mem_read_delay                                                 |
// | Purpose  : Delays the read strobe by LATENCY cycles to mark valid memRd.  |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module mem_read_delay #(
    parameter int LATENCY = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_strobe,
    output logic      o_capture
);

    logic [LATENCY-1:0] shift_q;
    logic [LATENCY-1:0] shift_d;

    generate
        if (LATENCY == 1) begin : g_single
            always_comb shift_d = i_strobe;
        end else begin : g_multi
            always_comb shift_d = {shift_q[LATENCY-2:0], i_strobe};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) shift_q <= '0;
        else        shift_q <= shift_d;
    end

    assign o_capture = shift_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/mem_dump_reader.sv
// ============================================================================
// | Module   : mem_dump_reader                                                |
// | Purpose  : Walks RAM from BASE_ADDR and streams each word over valid/     |
// |            ready; yields to core stores. Define CHECKSUM_EN to add a      |
// |            running 32-bit sum of accepted words.                          |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module mem_dump_reader
    import mem_reader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = RAM_BASE,
    parameter int                DEPTH        = 256,
    parameter int                READ_LATENCY = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [CNT_W-1:0]  count,
    mem_dump_reader_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      checksum
);

    state_t             state_q, state_d;
    logic               start_prev_q, start_prev_d;
    logic [CNT_W:0]     n_q, n_d;
    logic [CNT_W:0]     idx_q, idx_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               mem_re;
    logic               capture;
    logic               start_rise;

    assign start_rise = start & ~start_prev_q;

    mem_read_delay #(
        .LATENCY (READ_LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_strobe  (mem_re),
        .o_capture (capture)
    );

    always_comb begin
        state_d      = state_q;
        start_prev_d = start;
        n_d          = n_q;
        idx_d        = idx_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        mem_re       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    n_d     = clamp_count(count, DEPTH);
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The core's store owns the port this cycle.
                if (!bus.memWriteM) begin
                    mem_re  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (capture) begin
                    out_data_d  = bus.memRd;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.outReady) begin
                    out_valid_d = 1'b0;
                    // idx stays on the last word so memAddr never runs past the window.
                    if (idx_q == n_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            n_q          <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.memAddr  = BASE_ADDR + {{(ADDR_W-CNT_W-1){1'b0}}, idx_q};
    assign bus.memRe    = mem_re;
    assign bus.outData  = out_data_q;
    assign bus.outValid = out_valid_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              launch;
    logic              accept;

    assign launch = (state_q == IDLE) && start_rise;
    assign accept = (state_q == HOLD) && bus.outReady;

    always_comb begin
        checksum_d = checksum_q;
        if (launch)      checksum_d = '0;
        else if (accept) checksum_d = checksum_q + out_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
// ============================================================================
// | Module   : tb_mem_dump_reader                                             |
// | Purpose  : Self-checking bench for mem_dump_reader (DEPTH=4, latency 3).  |
// | Revision : 1.0 - initial release                                          |
// ============================================================================
`default_nettype none

module tb_mem_dump_reader;
    localparam int          TB_DEPTH = 4;
    localparam int          TB_LAT   = 3;
    localparam logic [31:0] BASE     = 32'd8500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    mem_dump_reader_if bus();

    mem_dump_reader #(
        .BASE_ADDR    (BASE),
        .DEPTH        (TB_DEPTH),
        .READ_LATENCY (TB_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count    (count),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // RAM model: reads return their word exactly TB_LAT cycles after memRe; noise otherwise.
    logic [31:0] ram     [TB_DEPTH];
    logic [31:0] rd_pipe [TB_LAT];

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        if (a >= BASE && a < BASE + TB_DEPTH) return ram[a - BASE];
        return 32'hDEAD_BEEF;
    endfunction

    initial for (int i = 0; i < TB_LAT; i++) rd_pipe[i] = '0;

    always @(posedge clk) begin
        for (int i = TB_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= bus.memRe ? ram_read(bus.memAddr) : $urandom;
    end

    assign bus.memRd = rd_pipe[TB_LAT-1];

    // Reference model: transaction-level expectations of one dump.
    int          cyc = 0;
    bit          m_idle, m_prev_start, m_expect_done, m_prev_valid, m_prev_ready;
    logic [31:0] m_prev_data, m_rd_addr, m_sum;
    int          m_rd_cycle, m_n, m_accepted, m_last_lat;
    logic [31:0] exp_addr_q[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          done_seen = 0;
    int          memre_seen = 0;
    bit          next_done;
    logic [31:0] exp_ck;
    logic [31:0] ea;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_idle = 1; m_prev_start = 0; m_expect_done = 0; m_prev_valid = 0;
            m_prev_ready = 0; m_rd_cycle = -1; m_sum = 0; m_accepted = 0; m_n = 0;
            exp_addr_q.delete();
        end else begin
`ifdef CHECKSUM_EN
            exp_ck = m_sum;
`else
            exp_ck = 32'd0;
`endif
            check("busy", {31'b0, busy}, {31'b0, !m_idle});
            check("done", {31'b0, done}, {31'b0, m_expect_done});
            check("checksum", checksum, exp_ck);
            if (m_idle) begin
                check("idle_memRe", {31'b0, bus.memRe}, 32'd0);
                check("idle_outValid", {31'b0, bus.outValid}, 32'd0);
            end
            if (bus.memRe) begin
                memre_seen++;
                check("read_during_store", {31'b0, bus.memWriteM}, 32'd0);
                check("read_overlap", {31'b0, (m_rd_cycle < 0 && !bus.outValid)}, 32'd1);
                if (exp_addr_q.size() == 0) begin
                    check("extra_read", 32'd1, 32'd0);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("memAddr", bus.memAddr, ea);
                end
                m_rd_cycle = cyc;
                m_rd_addr  = bus.memAddr;
                obs_addr.push_back(bus.memAddr);
            end
            if (bus.outValid && !m_prev_valid) begin
                check("valid_without_read", {31'b0, (m_rd_cycle >= 0)}, 32'd1);
                m_last_lat = cyc - m_rd_cycle;
                check("read_latency", m_last_lat, TB_LAT + 1);
                check("outData", bus.outData, ram_read(m_rd_addr));
                m_rd_cycle = -1;
            end else if (m_rd_cycle >= 0 && cyc - m_rd_cycle > TB_LAT + 1) begin
                check("read_timeout", 32'd1, 32'd0);
                m_rd_cycle = -1;
            end
            if (m_prev_valid && !m_prev_ready) begin
                check("hold_valid", {31'b0, bus.outValid}, 32'd1);
                check("hold_data", bus.outData, m_prev_data);
            end
            next_done = 0;
            if (bus.outValid && bus.outReady) begin
                m_accepted++;
                m_sum += bus.outData;
                obs_data.push_back(bus.outData);
                if (m_accepted == m_n) next_done = 1;
            end
            if (done) begin
                done_seen++;
                check("addr_drained", exp_addr_q.size(), 32'd0);
                m_idle = 1;
            end else if (m_idle && start && !m_prev_start) begin
                m_n = (count == 0 || count > TB_DEPTH) ? TB_DEPTH : int'(count);
                for (int i = 0; i < m_n; i++) exp_addr_q.push_back(BASE + i);
                m_accepted = 0;
                m_sum      = 0;
                m_idle     = 0;
            end
            m_expect_done = next_done;
            m_prev_valid  = bus.outValid;
            m_prev_ready  = bus.outReady;
            m_prev_data   = bus.outData;
            m_prev_start  = start;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles, input bit rnd);
        int d0 = done_seen;
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (rnd) begin
                bus.outReady  = ($urandom_range(0, 9) < 7);
                bus.memWriteM = ($urandom_range(0, 9) < 3);
                start         = $urandom_range(0, 1) == 1;
            end
            tick();
            if (done_seen > d0) break;
        end
        if (i == max_cycles) check("done_timeout", 32'd0, 32'd1);
        bus.outReady  = 1'b1;
        bus.memWriteM = 1'b0;
    endtask

    task automatic launch(input logic [15:0] c);
        obs_addr.delete();
        obs_data.delete();
        count = c;
        start = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memAddr"},  bus.memAddr, 32'd8500);
        check({tag, "_memRe"},    {31'b0, bus.memRe}, 32'd0);
        check({tag, "_outData"},  bus.outData, 32'd0);
        check({tag, "_outValid"}, {31'b0, bus.outValid}, 32'd0);
        check({tag, "_busy"},     {31'b0, busy}, 32'd0);
        check({tag, "_done"},     {31'b0, done}, 32'd0);
        check({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        int d0, m0, k;
        rst_n = 1'b0; start = 1'b0; count = '0;
        bus.memWriteM = 1'b0; bus.outReady = 1'b1;
        ram[0] = 32'd45; ram[1] = 32'd33; ram[2] = 32'd222; ram[3] = 32'd7;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_reset_outputs("reset");

        // Three-word dump with literal expectations.
        launch(16'd3);
        wait_done(200, 1'b0);
        start = 1'b0;
        check("t2_reads", obs_addr.size(), 32'd3);
        check("t2_words", obs_data.size(), 32'd3);
        if (obs_addr.size() == 3 && obs_data.size() == 3) begin
            check("t2_addr0", obs_addr[0], 32'd8500);
            check("t2_addr1", obs_addr[1], 32'd8501);
            check("t2_addr2", obs_addr[2], 32'd8502);
            check("t2_data0", obs_data[0], 32'd45);
            check("t2_data1", obs_data[1], 32'd33);
            check("t2_data2", obs_data[2], 32'd222);
        end
        check("t2_first_latency", m_last_lat, 32'd4);
        tick();
`ifdef CHECKSUM_EN
        check("t2_checksum", checksum, 32'd300);
`else
        check("t2_checksum", checksum, 32'd0);
`endif
        check("t2_busy_after", {31'b0, busy}, 32'd0);

        // Backpressure on the second word.
        d0 = done_seen;
        launch(16'd3);
        for (k = 0; k < 50 && obs_data.size() < 1; k++) tick();
        start = 1'b0;
        bus.outReady = 1'b0;
        for (k = 0; k < 50 && !bus.outValid; k++) tick();
        m0 = memre_seen;
        for (int i = 0; i < 5; i++) begin
            check("t3_held_data", bus.outData, 32'd33);
            check("t3_held_valid", {31'b0, bus.outValid}, 32'd1);
            tick();
        end
        check("t3_no_new_read", memre_seen - m0, 32'd0);
        bus.outReady = 1'b1;
        wait_done(200, 1'b0);
        check("t3_done_once", done_seen - d0, 32'd1);
        check("t3_words", obs_data.size(), 32'd3);

        // Store arbitration: memWriteM held over the first ISSUE cycles.
        tick();
        bus.memWriteM = 1'b1;
        launch(16'd2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4_stalled_memRe", {31'b0, bus.memRe}, 32'd0);
            tick();
        end
        bus.memWriteM = 1'b0;
        #1;
        check("t4_read_follows", {31'b0, bus.memRe}, 32'd1);
        check("t4_read_addr", bus.memAddr, 32'd8500);
        wait_done(200, 1'b0);
        check("t4_words", obs_data.size(), 32'd2);

        // count=0 dumps the full window; start held high must not retrigger.
        tick();
        d0 = done_seen;
        launch(16'd0);
        wait_done(200, 1'b0);
        repeat (10) tick();
        check("t5_done_once", done_seen - d0, 32'd1);
        check("t5_busy_idle", {31'b0, busy}, 32'd0);
        check("t5_reads", obs_addr.size(), 32'd4);
        if (obs_addr.size() > 0) check("t5_last_addr", obs_addr[obs_addr.size()-1], 32'd8503);
        start = 1'b0;
        tick();

        launch(16'd1);
        wait_done(200, 1'b0);
        start = 1'b0;
        check("count1_reads", obs_addr.size(), 32'd1);
        if (obs_addr.size() > 0) check("count1_addr", obs_addr[0], 32'd8500);
        tick();

        // Reset mid-dump aborts without done; a fresh dump then works.
        launch(16'd4);
        for (k = 0; k < 50 && !bus.outValid; k++) tick();
        start = 1'b0;
        d0 = done_seen;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (10) tick();
        check("midreset_no_done", done_seen - d0, 32'd0);
        launch(16'd2);
        wait_done(200, 1'b0);
        start = 1'b0;
        check("after_reset_words", obs_data.size(), 32'd2);
        tick();

        // Randomized dumps with random RAM, counts, backpressure and store traffic.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < TB_DEPTH; i++) ram[i] = $urandom;
            case ($urandom_range(0, 4))
                0:       launch(16'd0);
                1:       launch(16'd1);
                2:       launch(16'($urandom_range(5, 65535)));
                default: launch(16'($urandom_range(2, 4)));
            endcase
            tick();
            wait_done(400, 1'b1);
            start = 1'b0;
            repeat (2) tick();
            if (busy) wait_done(400, 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual %0d required %0d", 1, 0);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
